// File: rtl/npu_load_pkg.sv
// Shared widths, FSM state encodings and config check for the NPU RAM bulk loader.
package npu_load_pkg;

    localparam int unsigned WORD_W     = 32;
    localparam int unsigned LINE_W     = 256;
    localparam int unsigned WPL        = LINE_W / WORD_W;
    localparam int unsigned WCNT_W     = (WPL > 1) ? $clog2(WPL) : 1;
    localparam int unsigned NUM_LINES  = 16;
    localparam int unsigned LINE_IDX_W = $clog2(NUM_LINES);
    localparam int unsigned NUM_W      = LINE_IDX_W + 1;
    localparam int unsigned END_W      = NUM_W + 1;
    localparam int unsigned STATE_W    = 3;

    typedef logic [STATE_W-1:0] state_t;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_GRANT = 3'd1;
    localparam state_t ST_FILL  = 3'd2;
    localparam state_t ST_WRITE = 3'd3;
    localparam state_t ST_DONE  = 3'd4;

    // A load is legal when it covers 1..NUM_LINES lines without running past the last line.
    function automatic logic cfg_valid(input logic [LINE_IDX_W-1:0] first,
                                       input logic [NUM_W-1:0]      num);
        logic [END_W-1:0] end_line;
        end_line = END_W'(first) + END_W'(num);
        return (num != '0) && (num <= NUM_W'(NUM_LINES)) && (end_line <= END_W'(NUM_LINES));
    endfunction

endpackage

// File: rtl/npu_ram_load_ctrl_packer.sv
// Assembles stream words into one NPU RAM line; word k occupies bits [32k+31:32k].
module npu_line_packer
    import npu_load_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clr_i,
    input  logic              we_i,
    input  logic [WCNT_W-1:0] idx_i,
    input  logic [WORD_W-1:0] data_i,
    output logic [LINE_W-1:0] line_o
);

    logic [LINE_W-1:0] line_q;
    logic [LINE_W-1:0] line_d;

    // Clear wins over a simultaneous word write so a cancelled line leaves nothing behind.
    always_comb begin
        line_d = line_q;
        if (clr_i) begin
            line_d = '0;
        end else if (we_i) begin
            line_d[32'(idx_i) * WORD_W +: WORD_W] = data_i;
        end
    end

    // Line register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            line_q <= '0;
        end else begin
            line_q <= line_d;
        end
    end

    assign line_o = line_q;

endmodule

// File: rtl/npu_ram_load_ctrl.sv
// Bulk loader: packs a 32-bit word stream into NPU RAM lines and writes them through the selector's loader port.
module npu_ram_load_ctrl
    import npu_load_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  cfg_start_i,
    input  logic [LINE_IDX_W-1:0] cfg_first_line_i,
    input  logic [NUM_W-1:0]      cfg_num_lines_i,
    input  logic                  abort_i,
    input  logic                  npu_busy_i,
    input  logic                  s_valid_i,
    input  logic [WORD_W-1:0]     s_data_i,
    output logic                  s_ready_o,
    output logic                  ram_sel_o,
    output logic                  en_w_o,
    output logic [LINE_IDX_W-1:0] w_line_o,
    output logic [LINE_W-1:0]     line_data_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o
);

    state_t                state_q,    state_d;
    logic [WCNT_W-1:0]     word_cnt_q, word_cnt_d;
    logic [LINE_IDX_W-1:0] line_q,     line_d;
    logic [NUM_W-1:0]      left_q,     left_d;
    logic                  ram_sel_q,  ram_sel_d;
    logic                  en_w_q,     en_w_d;
    logic                  busy_q,     busy_d;
    logic                  done_q,     done_d;
    logic                  err_q,      err_d;
    logic                  hs_c;

    // Stream is only accepted while filling; ready is decoded straight from state.
    assign s_ready_o = (state_q == ST_FILL);
    assign hs_c      = s_ready_o & s_valid_i;

    // Next-state, counters and registered-output decode.
    always_comb begin
        state_d    = state_q;
        word_cnt_d = word_cnt_q;
        line_d     = line_q;
        left_d     = left_q;
        err_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cfg_start_i) begin
                    if (cfg_valid(cfg_first_line_i, cfg_num_lines_i)) begin
                        line_d     = cfg_first_line_i;
                        left_d     = cfg_num_lines_i;
                        word_cnt_d = '0;
                        state_d    = ST_GRANT;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_GRANT: begin
                if (!npu_busy_i) begin
                    state_d = ST_FILL;
                end
            end
            ST_FILL: begin
                if (hs_c) begin
                    if (word_cnt_q == WCNT_W'(WPL - 1)) begin
                        word_cnt_d = '0;
                        state_d    = ST_WRITE;
                    end else begin
                        word_cnt_d = word_cnt_q + WCNT_W'(1);
                    end
                end
            end
            ST_WRITE: begin
                if (left_q > NUM_W'(1)) begin
                    line_d     = line_q + LINE_IDX_W'(1);
                    left_d     = left_q - NUM_W'(1);
                    word_cnt_d = '0;
                    state_d    = ST_FILL;
                end else begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Abort drops everything; a write already on the port this cycle still lands.
        if (abort_i) begin
            state_d    = ST_IDLE;
            word_cnt_d = '0;
            line_d     = '0;
            left_d     = '0;
            err_d      = 1'b0;
        end

        ram_sel_d = (state_d == ST_FILL) || (state_d == ST_WRITE) || (state_d == ST_DONE);
        en_w_d    = (state_d == ST_WRITE);
        done_d    = (state_d == ST_DONE);
        busy_d    = (state_d != ST_IDLE);
    end

    // State, counters and output registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            word_cnt_q <= '0;
            line_q     <= '0;
            left_q     <= '0;
            ram_sel_q  <= 1'b0;
            en_w_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            word_cnt_q <= word_cnt_d;
            line_q     <= line_d;
            left_q     <= left_d;
            ram_sel_q  <= ram_sel_d;
            en_w_q     <= en_w_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    npu_line_packer u_packer (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .clr_i  (abort_i),
        .we_i   (hs_c),
        .idx_i  (word_cnt_q),
        .data_i (s_data_i),
        .line_o (line_data_o)
    );

    assign ram_sel_o = ram_sel_q;
    assign en_w_o    = en_w_q;
    assign w_line_o  = line_q;
    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign err_o     = err_q;

endmodule

// File: tb/tb_npu_ram_load_ctrl.sv
// Scoreboard bench for npu_ram_load_ctrl: expected line writes come from a line-level model of each load.
module tb_npu_ram_load_ctrl;

    localparam int TB_WPL    = 8;
    localparam int TB_LINE_W = 256;

    typedef struct {
        logic [3:0]           line;
        logic [TB_LINE_W-1:0] data;
    } wr_t;

    logic                 clk_i = 1'b0;
    logic                 rst_i;
    logic                 cfg_start_i;
    logic [3:0]           cfg_first_line_i;
    logic [4:0]           cfg_num_lines_i;
    logic                 abort_i;
    logic                 npu_busy_i;
    logic                 s_valid_i;
    logic [31:0]          s_data_i;
    logic                 s_ready_o;
    logic                 ram_sel_o;
    logic                 en_w_o;
    logic [3:0]           w_line_o;
    logic [TB_LINE_W-1:0] line_data_o;
    logic                 busy_o;
    logic                 done_o;
    logic                 err_o;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          start_cyc = 0;
    int          acc_cnt = 0;
    int          wr_cnt = 0;
    int          done_cnt = 0;
    bit          hs_pending = 1'b0;
    bit          gap_mode = 1'b0;
    bit          tog = 1'b0;
    bit          prev_en = 1'b0;
    logic [31:0] stream_q[$];
    wr_t         exp_wr_q[$];
    int          exp_done_q[$];

    npu_ram_load_ctrl dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .cfg_start_i      (cfg_start_i),
        .cfg_first_line_i (cfg_first_line_i),
        .cfg_num_lines_i  (cfg_num_lines_i),
        .abort_i          (abort_i),
        .npu_busy_i       (npu_busy_i),
        .s_valid_i        (s_valid_i),
        .s_data_i         (s_data_i),
        .s_ready_o        (s_ready_o),
        .ram_sel_o        (ram_sel_o),
        .en_w_o           (en_w_o),
        .w_line_o         (w_line_o),
        .line_data_o      (line_data_o),
        .busy_o           (busy_o),
        .done_o           (done_o),
        .err_o            (err_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [TB_LINE_W-1:0] act, input logic [TB_LINE_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Stream source: pops accepted words, optionally drops valid every other cycle.
    initial begin
        s_valid_i = 1'b0;
        s_data_i  = '0;
        forever begin
            @(posedge clk_i);
            #1;
            if (hs_pending && stream_q.size() > 0) void'(stream_q.pop_front());
            tog = ~tog;
            if (stream_q.size() > 0 && (!gap_mode || tog)) begin
                s_valid_i = 1'b1;
                s_data_i  = stream_q[0];
            end else begin
                s_valid_i = 1'b0;
                s_data_i  = $urandom;
            end
        end
    end

    // Monitor: compares every line write and done pulse against the scoreboard.
    initial begin
        wr_t e;
        int  ed;
        forever begin
            @(negedge clk_i);
            hs_pending = s_valid_i && s_ready_o;
            if (hs_pending) acc_cnt++;
            if (!rst_i) begin
                if (en_w_o) begin
                    wr_cnt++;
                    chk("write_not_adjacent", TB_LINE_W'(prev_en), '0);
                    if (exp_wr_q.size() == 0) begin
                        chk("unexpected_write", 1, 0);
                    end else begin
                        e = exp_wr_q.pop_front();
                        chk("write_line", TB_LINE_W'(w_line_o), TB_LINE_W'(e.line));
                        chk("write_data", line_data_o, e.data);
                        chk("write_ram_sel", TB_LINE_W'(ram_sel_o), 1);
                    end
                end
                if (done_o) begin
                    done_cnt++;
                    chk("done_after_write", TB_LINE_W'(prev_en), 1);
                    if (exp_done_q.size() == 0) begin
                        chk("unexpected_done", 1, 0);
                    end else begin
                        ed = exp_done_q.pop_front();
                        if (ed >= 0) chk("done_cycle", TB_LINE_W'(cyc), TB_LINE_W'(ed));
                    end
                end
            end
            prev_en = en_w_o;
        end
    end

    // Issues one start; legal loads get their words queued and expected writes pushed.
    task automatic start_load(input int first, input int num, input bit timed,
                              input int abort_after, input bit seq);
        bit          ok;
        wr_t         e;
        logic [31:0] w;
        ok = (num >= 1) && (num <= 16) && (first + num <= 16);
        @(posedge clk_i);
        #1;
        cfg_start_i      = 1'b1;
        cfg_first_line_i = 4'(first);
        cfg_num_lines_i  = 5'(num);
        start_cyc        = cyc;
        if (ok) begin
            if (abort_after >= 0) begin
                for (int k = 0; k < abort_after; k++) stream_q.push_back($urandom);
            end else begin
                for (int l = 0; l < num; l++) begin
                    e.line = 4'(first + l);
                    e.data = '0;
                    for (int k = 0; k < TB_WPL; k++) begin
                        w = seq ? 32'(l * TB_WPL + k + 1) : 32'($urandom);
                        e.data[k*32 +: 32] = w;
                        stream_q.push_back(w);
                    end
                    exp_wr_q.push_back(e);
                end
                exp_done_q.push_back(timed ? start_cyc + 2 + num * (TB_WPL + 1) : -1);
            end
        end
        @(posedge clk_i);
        #1;
        cfg_start_i      = 1'b0;
        cfg_first_line_i = 4'($urandom);
        cfg_num_lines_i  = 5'($urandom);
        @(negedge clk_i);
        if (ok) begin
            chk("start_accept", TB_LINE_W'({busy_o, err_o, ram_sel_o}), TB_LINE_W'(3'b100));
        end else begin
            chk("start_reject", TB_LINE_W'({err_o, busy_o, ram_sel_o}), TB_LINE_W'(3'b100));
            @(negedge clk_i);
            chk("err_pulse_width", TB_LINE_W'({err_o, busy_o}), 0);
        end
    endtask

    // Waits (bounded) for the loader to return to idle and the scoreboard to drain.
    task automatic wait_idle();
        int n;
        n = 0;
        while (busy_o && n < 3000) begin
            @(negedge clk_i);
            n++;
        end
        chk("idle_timeout", TB_LINE_W'(busy_o), 0);
        chk("scoreboard_drained", TB_LINE_W'(exp_wr_q.size() + exp_done_q.size()), 0);
        exp_wr_q.delete();
        exp_done_q.delete();
        stream_q.delete();
    endtask

    initial begin
        bit bad;
        int n, wr0, d0, a0, first, num;
        rst_i            = 1'b1;
        cfg_start_i      = 1'b0;
        cfg_first_line_i = '0;
        cfg_num_lines_i  = '0;
        abort_i          = 1'b0;
        npu_busy_i       = 1'b0;

        // Reset and quiet idle.
        @(posedge clk_i);
        @(negedge clk_i);
        chk("reset_outputs", TB_LINE_W'({s_ready_o, ram_sel_o, en_w_o, w_line_o, busy_o, done_o, err_o}), 0);
        chk("reset_line_data", line_data_o, 0);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        bad = 1'b0;
        repeat (20) begin
            @(negedge clk_i);
            if (s_ready_o || ram_sel_o || busy_o || en_w_o || done_o) bad = 1'b1;
        end
        chk("idle_quiet", TB_LINE_W'(bad), 0);

        // Single line, words 1..8 back to back, timed.
        wr0 = wr_cnt;
        start_load(3, 1, 1'b1, -1, 1'b1);
        wait_idle();
        chk("single_write_count", TB_LINE_W'(wr_cnt - wr0), 1);

        // Grant wait: NPU busy for 5 cycles after start.
        npu_busy_i = 1'b1;
        start_load(0, 1, 1'b0, -1, 1'b0);
        bad = 1'b0;
        repeat (5) begin
            @(negedge clk_i);
            if (ram_sel_o || s_ready_o) bad = 1'b1;
        end
        chk("grant_hold", TB_LINE_W'(bad), 0);
        @(posedge clk_i);
        #1;
        npu_busy_i = 1'b0;
        @(negedge clk_i);
        chk("grant_still_waiting", TB_LINE_W'({s_ready_o, ram_sel_o}), 0);
        @(negedge clk_i);
        chk("grant_fill_entry", TB_LINE_W'({s_ready_o, ram_sel_o}), TB_LINE_W'(2'b11));
        wait_idle();

        // Multi-line with valid gaps, ending on the last line.
        gap_mode = 1'b1;
        wr0 = wr_cnt;
        start_load(14, 2, 1'b0, -1, 1'b0);
        wait_idle();
        chk("multi_write_count", TB_LINE_W'(wr_cnt - wr0), 2);
        gap_mode = 1'b0;

        // Rejected configurations.
        start_load(10, 7, 1'b0, -1, 1'b0);
        start_load(0, 0, 1'b0, -1, 1'b0);
        start_load(0, 17, 1'b0, -1, 1'b0);

        // Abort after word 5 of line 0, then a clean reload.
        wr0 = wr_cnt;
        d0  = done_cnt;
        a0  = acc_cnt;
        start_load(5, 2, 1'b0, 6, 1'b0);
        n = 0;
        while ((acc_cnt - a0) < 6 && n < 500) begin
            @(negedge clk_i);
            n++;
        end
        chk("abort_words_taken", TB_LINE_W'(acc_cnt - a0), 6);
        @(posedge clk_i);
        #1;
        abort_i = 1'b1;
        @(posedge clk_i);
        #1;
        abort_i = 1'b0;
        @(negedge clk_i);
        chk("abort_outputs", TB_LINE_W'({s_ready_o, ram_sel_o, en_w_o, busy_o, done_o}), 0);
        chk("abort_line_cleared", line_data_o, 0);
        repeat (3) @(negedge clk_i);
        chk("abort_no_write_done", TB_LINE_W'((wr_cnt - wr0) + (done_cnt - d0)), 0);
        stream_q.delete();
        start_load(5, 2, 1'b1, -1, 1'b0);
        wait_idle();

        // Randomized loads and starts, legal or not.
        for (int it = 0; it < 12; it++) begin
            first    = $urandom_range(0, 15);
            num      = $urandom_range(0, 18);
            gap_mode = 1'($urandom_range(0, 1));
            wr0      = wr_cnt;
            start_load(first, num, !gap_mode, -1, 1'b0);
            if ((num >= 1) && (num <= 16) && (first + num <= 16)) begin
                wait_idle();
                chk("rand_write_count", TB_LINE_W'(wr_cnt - wr0), TB_LINE_W'(num));
            end
        end
        gap_mode = 1'b0;

        repeat (3) @(negedge clk_i);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
